uart_tx8: RTL



---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx8_if.sv | 24 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx8.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, frame length and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Unknown parity codes fall back to no parity bit.
  function automatic int eff_parity(input int parity);
    return (parity == PAR_EVEN || parity == PAR_ODD) ? parity : PAR_NONE;
  endfunction

  function automatic int clamp_stop_bits(input int stop_bits);
    if (stop_bits < 1) return 1;
    if (stop_bits > 2) return 2;
    return stop_bits;
  endfunction

  // Line bits per frame: start + 8 data + optional parity + stop bits.
  function automatic int frame_bits(input int parity, input int stop_bits);
    return 9 + ((eff_parity(parity) != PAR_NONE) ? 1 : 0) + clamp_stop_bits(stop_bits);
  endfunction

  // Chain of two-input XOR gates, bit 0 through bit 7.
  function automatic logic xor8(input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ d[i];
    end
    return acc;
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input int parity);
    return (eff_parity(parity) == PAR_ODD) ? ~xor8(d) : xor8(d);
  endfunction

endpackage

// File: rtl/uart_tx8_if.sv
// Byte-load handshake and serial line of the 8-bit UART transmitter.
interface uart_tx8_if;
  logic [7:0] data;
  logic       load;
  logic       ready;
  logic       busy;
  logic       tx;

  modport master (
    output data,
    output load,
    input  ready,
    input  busy,
    input  tx
  );

  modport slave (
    input  data,
    input  load,
    output ready,
    output busy,
    output tx
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Modulo-CLKS_PER_BIT bit-period counter; bit_done marks the last cycle of each line bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear || count_reg == LAST) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bit_done = (count_reg == LAST) && !clear;

endmodule

// File: rtl/uart_tx8.sv
// 8-bit UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx8
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1
) (
  input logic       clk,
  input logic       reset_n,
  uart_tx8_if.slave bus
);

  localparam int   PAR_MODE  = eff_parity(PARITY);
  localparam int   N_STOP    = clamp_stop_bits(STOP_BITS);
  localparam logic LAST_STOP = (N_STOP == 2) ? 1'b1 : 1'b0;

  uart_state_t state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  idx_reg, idx_next;
  logic        par_reg, par_next;
  logic        stop_reg, stop_next;
  logic        tx_reg, tx_next;
  logic        ready_reg, ready_next;
  logic        bit_done;

  // The counter is held at zero while idle so the start bit gets a full period.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_reg == IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      par_reg   <= 1'b0;
      stop_reg  <= 1'b0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      par_reg   <= par_next;
      stop_reg  <= stop_next;
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
    end
  end

  // tx_next is the level of the bit entered on this edge, keeping tx a plain register.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    par_next   = par_reg;
    stop_next  = stop_reg;
    tx_next    = tx_reg;
    ready_next = ready_reg;
    unique case (state_reg)
      IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        if (bus.load && ready_reg) begin
          shift_next = bus.data;
          par_next   = parity_bit(bus.data, PAR_MODE);
          idx_next   = '0;
          stop_next  = 1'b0;
          state_next = START;
          tx_next    = 1'b0;
          ready_next = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
        end
      end
      DATA: begin
        if (bit_done) begin
          idx_next = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            if (PAR_MODE != PAR_NONE) begin
              state_next = uart_pkg::PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          tx_next = 1'b1;
          if (stop_reg == LAST_STOP) begin
            state_next = IDLE;
            ready_next = 1'b1;
          end else begin
            stop_next = stop_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

  assign bus.tx    = tx_reg;
  assign bus.ready = ready_reg;
  assign bus.busy  = ~ready_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      assert (PARITY == PAR_NONE || PARITY == PAR_EVEN || PARITY == PAR_ODD)
        else $error("uart_tx8: PARITY=%0d is not 0..2, treated as none", PARITY);
      assert (STOP_BITS == 1 || STOP_BITS == 2)
        else $error("uart_tx8: STOP_BITS=%0d clamped to 1..2", STOP_BITS);
    end
  end

endmodule
